// File: rtl/gemv_serial_collector.sv
// rtl/gemv_serial_collector.sv - Per-row bit-serial word assembly with round-robin output arbitration
// Each row shifts in LSB-first bits, parks completed words in a holding register, and one output register drains them.
module gemv_serial_collector #(
  parameter int BLK_ROW_CNT = 32,
  parameter int WORD_WIDTH = 16,
  localparam int ROW_ID_WIDTH = (BLK_ROW_CNT > 1) ? $clog2(BLK_ROW_CNT) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    serialIn      [BLK_ROW_CNT-1:0],
  input  logic                    serialInValid [BLK_ROW_CNT-1:0],
  output logic [WORD_WIDTH-1:0]   outData,
  output logic [ROW_ID_WIDTH-1:0] outRowId,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    overflow
);

  localparam int CNT_WIDTH = $clog2(WORD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(WORD_WIDTH - 1);

  logic [CNT_WIDTH-1:0]    bitCount [BLK_ROW_CNT-1:0];
  logic [WORD_WIDTH-1:0]   shiftReg [BLK_ROW_CNT-1:0];
  logic [WORD_WIDTH-1:0]   holdReg  [BLK_ROW_CNT-1:0];
  logic [BLK_ROW_CNT-1:0]  holdFull;
  logic [ROW_ID_WIDTH-1:0] lastGrantedRow;

  logic [ROW_ID_WIDTH-1:0] grantIdx;
  logic [ROW_ID_WIDTH-1:0] candIdx;
  logic                    grantFound;
  logic                    loadOut;
  logic [BLK_ROW_CNT-1:0]  clearHold;

  // Round-robin search starting just after the last granted row.
  always_comb begin
    grantIdx   = '0;
    candIdx    = '0;
    grantFound = 1'b0;
    for (int i = 1; i <= BLK_ROW_CNT; i++) begin
      candIdx = ROW_ID_WIDTH'((int'(lastGrantedRow) + i) % BLK_ROW_CNT);
      if (!grantFound && holdFull[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  assign loadOut = grantFound && (!outValid || outReady);

  always_comb begin
    clearHold = '0;
    if (loadOut) begin
      clearHold[grantIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < BLK_ROW_CNT; r++) begin
        bitCount[r] <= '0;
        shiftReg[r] <= '0;
        holdReg[r]  <= '0;
      end
      holdFull       <= '0;
      outValid       <= 1'b0;
      outData        <= '0;
      outRowId       <= '0;
      overflow       <= 1'b0;
      lastGrantedRow <= ROW_ID_WIDTH'(BLK_ROW_CNT - 1);
    end else begin
      if (loadOut) begin
        outData        <= holdReg[grantIdx];
        outRowId       <= grantIdx;
        outValid       <= 1'b1;
        lastGrantedRow <= grantIdx;
      end else if (outReady) begin
        outValid <= 1'b0;
      end

      for (int r = 0; r < BLK_ROW_CNT; r++) begin
        if (clearHold[r]) begin
          holdFull[r] <= 1'b0;
        end
        if (serialInValid[r]) begin
          if (bitCount[r] == LAST_BIT) begin
            bitCount[r] <= '0;
            // A slot being drained this edge is free for the incoming word.
            if (!holdFull[r] || clearHold[r]) begin
              holdReg[r]  <= {serialIn[r], shiftReg[r][WORD_WIDTH-2:0]};
              holdFull[r] <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            shiftReg[r][bitCount[r]] <= serialIn[r];
            bitCount[r]              <= bitCount[r] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gemv_serial_collector.sv
// tb/tb_gemv_serial_collector.sv - Directed self-checking bench for gemv_serial_collector
// Inputs change and outputs are sampled on the falling edge.
module tb_gemv_serial_collector;

  localparam int ROWS = 32;
  localparam int WW = 16;

  logic          clk;
  logic          reset;
  logic          serialIn      [ROWS-1:0];
  logic          serialInValid [ROWS-1:0];
  logic [WW-1:0] outData;
  logic [4:0]    outRowId;
  logic          outValid;
  logic          outReady;
  logic          overflow;

  int errors;
  int checks;

  gemv_serial_collector #(.BLK_ROW_CNT(ROWS), .WORD_WIDTH(WW)) dut (
    .clk(clk),
    .reset(reset),
    .serialIn(serialIn),
    .serialInValid(serialInValid),
    .outData(outData),
    .outRowId(outRowId),
    .outValid(outValid),
    .outReady(outReady),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearAll();
    for (int r = 0; r < ROWS; r++) begin
      serialIn[r]      = 1'b0;
      serialInValid[r] = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    clearAll();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Leaves the last bit on the lines; the next rising edge captures it.
  task automatic sendWord(input int row, input logic [WW-1:0] word, input int gap);
    for (int b = 0; b < WW; b++) begin
      @(negedge clk);
      clearAll();
      serialIn[row]      = word[b];
      serialInValid[row] = 1'b1;
      if (b != WW - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          clearAll();
          serialIn[row] = 1'($urandom_range(1, 0));
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    outReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        serialIn[r]      = 1'($urandom_range(1, 0));
        serialInValid[r] = 1'b1;
      end
      @(negedge clk);
    end
    reset = 1'b0;
    clearAll();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b expected 0", outValid); end
    checks++; if (outData !== 16'h0) begin errors++; $display("FAIL reset_outData: got %h expected 0000", outData); end
    checks++; if (outRowId !== 5'd0) begin errors++; $display("FAIL reset_outRowId: got %0d expected 0", outRowId); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_single_word();
    outReady = 1'b1;
    sendWord(3, 16'hA5C3, 0);
    @(negedge clk);
    clearAll();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", outValid); end
    @(negedge clk);
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", outValid); end
    checks++; if (outData !== 16'hA5C3) begin errors++; $display("FAIL single_data: got %h expected a5c3", outData); end
    checks++; if (outRowId !== 5'd3) begin errors++; $display("FAIL single_row: got %0d expected 3", outRowId); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b expected 0", overflow); end
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL single_one_beat: got %b expected 0", outValid); end
  endtask

  task automatic test_gaps();
    outReady = 1'b1;
    sendWord(5, 16'h0001, 3);
    @(negedge clk);
    clearAll();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid: got %b expected 0", outValid); end
    @(negedge clk);
    checks++; if (outValid !== 1'b1 || outData !== 16'h0001 || outRowId !== 5'd5) begin
      errors++; $display("FAIL gaps_beat: got valid=%b data=%h row=%0d expected valid=1 data=0001 row=5", outValid, outData, outRowId);
    end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] rowWord;
    doReset();
    outReady = 1'b1;
    for (int b = 0; b < WW; b++) begin
      @(negedge clk);
      for (int r = 0; r < ROWS; r++) begin
        rowWord          = WW'(r);
        serialIn[r]      = rowWord[b];
        serialInValid[r] = 1'b1;
      end
    end
    @(negedge clk);
    clearAll();
    for (int i = 0; i < ROWS; i++) begin
      @(negedge clk);
      checks++; if (outValid !== 1'b1 || outRowId !== 5'(i) || outData !== WW'(i)) begin
        errors++; $display("FAIL b2b_beat%0d: got valid=%b row=%0d data=%h expected valid=1 row=%0d data=%h", i, outValid, outRowId, outData, i, WW'(i));
      end
    end
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", outValid); end
  endtask

  task automatic test_overflow();
    doReset();
    outReady = 1'b0;
    sendWord(7, 16'h7777, 0);
    sendWord(2, 16'h1111, 0);
    sendWord(2, 16'h2222, 0);
    @(negedge clk);
    clearAll();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (outValid !== 1'b1 || outData !== 16'h7777 || outRowId !== 5'd7) begin
        errors++; $display("FAIL ovf_stall%0d: got valid=%b data=%h row=%0d expected valid=1 data=7777 row=7", c, outValid, outData, outRowId);
      end
      @(negedge clk);
    end
    outReady = 1'b1;
    @(negedge clk);
    checks++; if (outValid !== 1'b1 || outData !== 16'h1111 || outRowId !== 5'd2) begin
      errors++; $display("FAIL ovf_kept_word: got valid=%b data=%h row=%0d expected valid=1 data=1111 row=2", outValid, outData, outRowId);
    end
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL ovf_dropped_word: got valid=%b data=%h expected valid=0", outValid, outData); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_midword();
    outReady = 1'b1;
    for (int b = 0; b < 7; b++) begin
      @(negedge clk);
      clearAll();
      serialInValid[0] = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    serialIn[0] = 1'b1;
    serialInValid[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clearAll();
    checks++; if (outValid !== 1'b0 || outData !== 16'h0 || outRowId !== 5'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got valid=%b data=%h row=%0d ovf=%b expected all 0", outValid, outData, outRowId, overflow);
    end
    sendWord(0, 16'hFFFF, 0);
    @(negedge clk);
    clearAll();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midreset_early: got valid=%b data=%h expected valid=0", outValid, outData); end
    @(negedge clk);
    checks++; if (outValid !== 1'b1 || outData !== 16'hFFFF || outRowId !== 5'd0) begin
      errors++; $display("FAIL midreset_word: got valid=%b data=%h row=%0d expected valid=1 data=ffff row=0", outValid, outData, outRowId);
    end
  endtask

  task automatic test_drain_collision();
    logic [WW-1:0] beef;
    beef = 16'hBEEF;
    doReset();
    outReady = 1'b0;
    sendWord(4, 16'h4444, 0);
    sendWord(1, 16'h1234, 0);
    for (int b = 0; b < WW; b++) begin
      @(negedge clk);
      clearAll();
      if (b == WW - 1) begin
        checks++; if (outValid !== 1'b1 || outData !== 16'h4444) begin
          errors++; $display("FAIL drain_stalled: got valid=%b data=%h expected valid=1 data=4444", outValid, outData);
        end
        outReady = 1'b1;
      end
      serialIn[1]      = beef[b];
      serialInValid[1] = 1'b1;
    end
    @(negedge clk);
    clearAll();
    checks++; if (outValid !== 1'b1 || outData !== 16'h1234 || outRowId !== 5'd1) begin
      errors++; $display("FAIL drain_old_word: got valid=%b data=%h row=%0d expected valid=1 data=1234 row=1", outValid, outData, outRowId);
    end
    @(negedge clk);
    checks++; if (outValid !== 1'b1 || outData !== 16'hBEEF || outRowId !== 5'd1) begin
      errors++; $display("FAIL drain_new_word: got valid=%b data=%h row=%0d expected valid=1 data=beef row=1", outValid, outData, outRowId);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL drain_overflow: got %b expected 0", overflow); end
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL drain_end: got %b expected 0", outValid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    outReady = 1'b0;
    clearAll();
    test_reset();
    test_single_word();
    test_gaps();
    test_back_to_back();
    test_overflow();
    test_reset_midword();
    test_drain_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
